alu_rr_sched: RTL and testbench
===============================

// Module: alu_rr_sched
// PURPOSE
// - Round-robin scheduler sharing one instance of the 32-bit combinational alu among N_REQ requesters.
// - Each requester presents (a, b, op) under a valid/ready handshake.
// - The scheduler grants one request, latches its operands and drives the ALU from those latches.
// - It registers the result and returns it on a single response channel tagged with the requester id.
// - Sits between issue logic and the ALU, so the ALU itself stays purely combinational.
// PARAMETERS
// - N_REQ   4   number of requesters (2..8); ID_W = $clog2(N_REQ)
// PORTS
// - i_clk          in   1            clock; all state updates on posedge
// - i_rst_n        in   1            reset, asynchronous, active-low
// - i_req_valid    in   N_REQ        per-requester request valid
// - o_req_ready    out  N_REQ        per-requester accept; at most one bit high
// - i_req_a        in   N_REQ x 32   operand a, per requester
// - i_req_b        in   N_REQ x 32   operand b, per requester
// - i_req_op       in   N_REQ x 4    opcode (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), per requester
// - o_rsp_valid    out  1            response valid
// - i_rsp_ready    in   1            response consumer ready
// - o_rsp_res      out  32           ALU result
// - o_rsp_id       out  ID_W         index of the requester that issued the op
// - o_rsp_err      out  1            opcode was not a defined opcode; o_rsp_res forced to 0
// BEHAVIOUR
// - Reset values: state=IDLE, rr_ptr=0, o_rsp_valid=0, o_rsp_res=0, o_rsp_id=0, o_rsp_err=0, operand latches=0.
// - FSM states IDLE, EXEC, RESP.
//   - IDLE: if any valid, go to EXEC.
//   - EXEC (one cycle): register the ALU output into o_rsp_*, then go to RESP.
//   - RESP: hold the o_rsp_* fields stable with o_rsp_valid=1 until i_rsp_ready.
//     - On the response handshake with no new accept, go to IDLE.
//     - If a new request is accepted in the same cycle, go to EXEC.
// - Accept window: IDLE, or RESP with i_rsp_ready=1.
// - o_req_ready is combinational: one-hot on the granted requester, and only within the accept window.
// - Grant: first asserted i_req_valid found by scanning upward from rr_ptr, wrapping N_REQ-1 -> 0.
// - On accept: latch a/b/op/id, set rr_ptr = grant+1 mod N_REQ.
// - Latency: accept at cycle t -> o_rsp_valid=1 at t+2.
//   - Peak throughput is one op per 2 cycles (accept overlaps the RESP handshake).
// - Requesters hold valid/a/b/op stable until accepted; the scheduler never drops an asserted valid.
// - A non-granted requester sees ready=0 and keeps waiting.
// - The scheduler checks the opcode in EXEC; undefined encodings give o_rsp_err=1 and res=0.
// - Async reset mid-operation clears all state immediately; any in-flight op is discarded, with no response.
// STRUCTURE
// - Shared package alu_pkg holds:
//   - the 4-bit opcode typedef alu_op_t plus its encodings
//     - ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13;
//   - function is_legal_op().
//   - opcode.svh becomes a thin include of alu_pkg.
// - Sub-module rr_arbiter: N_REQ requests + pointer in, one-hot grant + encoded index out, purely combinational.
// - Instantiates alu unchanged, fed from the operand latches.
// TESTING
// 1. req0 ADD a=5 b=3, rsp_ready=1 -> ready0 at t0, rsp_valid at t0+2, res=8, id=0, err=0.
// 2. All 4 valid at once: ADD 5,3 / SUB 5,3 / XOR 0xA,0xC / AND 0xA,0xC, rsp_ready=1
//    -> ids 0,1,2,3 in order, res 8,2,0x6,0x8, one accept every 2 cycles.
// 3. req2 SLL 0x5,3, rsp_ready=0 for 5 cycles
//    -> res=0x28 held stable, rsp_valid high, all o_req_ready=0 until rsp_ready rises.
// 4. req1 SRA 0xFFFFFFF2,2 then SRL 0xFFFFFFF2,2 back-to-back
//    -> res 0xFFFFFFFC then 0x3FFFFFFC; second accept coincides with the first response handshake.
// 5. req3 op=4'hF a=1 b=1 -> rsp_valid with res=0, err=1, id=3; next op from the same requester is normal.
// 6. Accept req1, rr_ptr=2, then drop i_rst_n during EXEC
//    -> rsp_valid=0 at once, no response; after reset, req0 and req1 both valid -> req0 granted first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, scheduler states and the opcode legality check.
// Used by the ALU, the round-robin scheduler and its testbench.
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SLL  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_AND  = 4'd7,
      ALU_SUB  = 4'd8,
      ALU_SRA  = 4'd13
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } sched_state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; undefined opcodes produce zero.
module alu
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [3:0]      i_op,
   output logic [XLEN-1:0] o_res
);

   logic [4:0] shamt;

   assign shamt = i_b[4:0];

   always_comb begin
      o_res = '0;
      case (alu_op_t'(i_op))
         ALU_ADD:  o_res = i_a + i_b;
         ALU_SUB:  o_res = i_a - i_b;
         ALU_SLL:  o_res = i_a << shamt;
         ALU_SLT:  o_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
         ALU_XOR:  o_res = i_a ^ i_b;
         ALU_SRL:  o_res = i_a >> shamt;
         ALU_SRA:  o_res = $unsigned($signed(i_a) >>> shamt);
         ALU_OR:   o_res = i_a | i_b;
         ALU_AND:  o_res = i_a & i_b;
         default:  o_res = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request scanning
// upward from i_ptr with wrap-around, and reports it one-hot and encoded.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_grant_idx,
   output logic             o_grant_valid
);

   int          cand;
   logic [ID_W-1:0] cand_idx;

   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      cand          = 0;
      cand_idx      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand     = (int'(i_ptr) + i) % N_REQ;
         cand_idx = ID_W'(cand);
         if (!o_grant_valid && i_req[cand_idx]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = cand_idx;
         end
      end
   end

   assign o_grant = o_grant_valid ? (N_REQ'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational ALU among N_REQ requesters,
// with latched operands, a registered result and an id-tagged response channel.
module alu_rr_sched
   import alu_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic [N_REQ-1:0]           i_req_valid,
   output logic [N_REQ-1:0]           o_req_ready,
   input  logic [N_REQ-1:0][XLEN-1:0] i_req_a,
   input  logic [N_REQ-1:0][XLEN-1:0] i_req_b,
   input  logic [N_REQ-1:0][3:0]      i_req_op,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [XLEN-1:0]            o_rsp_res,
   output logic [ID_W-1:0]            o_rsp_id,
   output logic                       o_rsp_err
);

   sched_state_t    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [3:0]      op_q, op_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_res_q, rsp_res_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic            rsp_err_q, rsp_err_d;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_valid;
   logic             accept_window;
   logic             accept;
   logic [XLEN-1:0]  alu_res;
   logic             op_legal;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .i_req         (i_req_valid),
      .i_ptr         (rr_ptr_q),
      .o_grant       (grant),
      .o_grant_idx   (grant_idx),
      .o_grant_valid (grant_valid)
   );

   alu u_alu (
      .i_a   (a_q),
      .i_b   (b_q),
      .i_op  (op_q),
      .o_res (alu_res)
   );

   // A new request can overlap the response handshake, giving one op every two cycles.
   assign accept_window = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
   assign accept        = accept_window && grant_valid;
   assign o_req_ready   = accept ? grant : '0;
   assign op_legal      = is_legal_op(op_q);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_res_d   = rsp_res_q;
      rsp_id_d    = rsp_id_q;
      rsp_err_d   = rsp_err_q;

      if (accept) begin
         a_d      = i_req_a[grant_idx];
         b_d      = i_req_b[grant_idx];
         op_d     = i_req_op[grant_idx];
         id_d     = grant_idx;
         rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = op_legal ? alu_res : '0;
            rsp_err_d   = !op_legal;
            rsp_id_d    = id_q;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept ? ST_EXEC : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_res_q   <= '0;
         rsp_id_q    <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_res_q   <= rsp_res_d;
         rsp_id_q    <= rsp_id_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_res   = rsp_res_q;
   assign o_rsp_id    = rsp_id_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed testbench for alu_rr_sched: hand-computed vectors for grant order,
// latency, back-pressure, back-to-back issue, illegal opcodes and async reset.
module tb_alu_rr_sched;
   import alu_pkg::*;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                       clk = 1'b0;
   logic                       rst_n = 1'b0;
   logic [N_REQ-1:0]           req_valid = '0;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0][31:0]     req_a = '0;
   logic [N_REQ-1:0][31:0]     req_b = '0;
   logic [N_REQ-1:0][3:0]      req_op = '0;
   logic                       rsp_valid;
   logic                       rsp_ready = 1'b0;
   logic [31:0]                rsp_res;
   logic [ID_W-1:0]            rsp_id;
   logic                       rsp_err;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int lastAccept = 0;

   logic [31:0] t2Res [4] = '{32'd8, 32'd2, 32'h6, 32'h8};

   alu_rr_sched #(.N_REQ(N_REQ)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_op    (req_op),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_res   (rsp_res),
      .o_rsp_id    (rsp_id),
      .o_rsp_err   (rsp_err)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      req_a[idx]     = a;
      req_b[idx]     = b;
      req_op[idx]    = op;
      req_valid[idx] = 1'b1;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkRsp(input string tag, input logic [31:0] res, input logic [31:0] id, input logic err);
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_res"}, rsp_res, res);
      checkOutput({tag, "_id"}, 32'(rsp_id), id);
      checkOutput({tag, "_err"}, 32'(rsp_err), 32'(err));
   endtask

   task automatic doReset;
      req_valid = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // reset values while reset is held
      @(negedge clk);
      #1;
      checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_res", rsp_res, 32'd0);
      checkOutput("rst_id", 32'(rsp_id), 32'd0);
      checkOutput("rst_err", 32'(rsp_err), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      doReset();

      // Test 1: single ADD, latency two cycles
      applyStimulus(0, 32'd5, 32'd3, 4'(ALU_ADD));
      rsp_ready = 1'b1;
      #1;
      checkOutput("t1_ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid[0] = 1'b0;
      #1;
      checkOutput("t1_exec_valid", 32'(rsp_valid), 32'd0);
      tick();
      #1;
      checkRsp("t1", 32'd8, 32'd0, 1'b0);
      tick();
      #1;
      checkOutput("t1_done_valid", 32'(rsp_valid), 32'd0);

      // Test 2: all four requesters at once, served 0,1,2,3
      doReset();
      applyStimulus(0, 32'd5, 32'd3, 4'(ALU_ADD));
      applyStimulus(1, 32'd5, 32'd3, 4'(ALU_SUB));
      applyStimulus(2, 32'hA, 32'hC, 4'(ALU_XOR));
      applyStimulus(3, 32'hA, 32'hC, 4'(ALU_AND));
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("t2_ready%0d", k), 32'(req_ready), 32'(1) << k);
         if (k > 0) checkOutput($sformatf("t2_gap%0d", k), 32'(cyc - lastAccept), 32'd2);
         lastAccept = cyc;
         tick();
         req_valid[k] = 1'b0;
         tick();
         #1;
         checkRsp($sformatf("t2_rsp%0d", k), t2Res[k], 32'(k), 1'b0);
      end
      tick();
      #1;
      checkOutput("t2_idle_valid", 32'(rsp_valid), 32'd0);

      // Test 3: back-pressure holds the response and blocks new accepts
      applyStimulus(2, 32'h5, 32'd3, 4'(ALU_SLL));
      rsp_ready = 1'b0;
      #1;
      checkOutput("t3_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid[2] = 1'b0;
      applyStimulus(0, 32'd1, 32'd1, 4'(ALU_ADD));
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         checkOutput($sformatf("t3_hold_res%0d", k), rsp_res, 32'h28);
         checkOutput($sformatf("t3_hold_valid%0d", k), 32'(rsp_valid), 32'd1);
         checkOutput($sformatf("t3_hold_ready%0d", k), 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checkOutput("t3_ready_after", 32'(req_ready), 32'b0001);
      tick();
      req_valid[0] = 1'b0;
      tick();
      #1;
      checkRsp("t3_next", 32'd2, 32'd0, 1'b0);
      tick();

      // Test 4: SRA then SRL from the same requester, back-to-back
      applyStimulus(1, 32'hFFFF_FFF2, 32'd2, 4'(ALU_SRA));
      #1;
      checkOutput("t4_ready_a", 32'(req_ready), 32'b0010);
      tick();
      req_op[1] = 4'(ALU_SRL);
      tick();
      #1;
      checkRsp("t4_sra", 32'hFFFF_FFFC, 32'd1, 1'b0);
      checkOutput("t4_ready_b", 32'(req_ready), 32'b0010);
      tick();
      req_valid[1] = 1'b0;
      tick();
      #1;
      checkRsp("t4_srl", 32'h3FFF_FFFC, 32'd1, 1'b0);
      tick();

      // Test 5: undefined opcode, then a normal op from the same requester
      applyStimulus(3, 32'd1, 32'd1, 4'hF);
      #1;
      checkOutput("t5_ready", 32'(req_ready), 32'b1000);
      tick();
      req_valid[3] = 1'b0;
      tick();
      #1;
      checkRsp("t5_bad", 32'd0, 32'd3, 1'b1);
      tick();
      applyStimulus(3, 32'd2, 32'd3, 4'(ALU_ADD));
      tick();
      req_valid[3] = 1'b0;
      tick();
      #1;
      checkRsp("t5_good", 32'd5, 32'd3, 1'b0);
      tick();

      // Test 6: reset during EXEC discards the op and rewinds the pointer
      applyStimulus(1, 32'd7, 32'd1, 4'(ALU_ADD));
      #1;
      checkOutput("t6_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid[1] = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_valid", 32'(rsp_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      #1;
      checkOutput("t6_no_rsp", 32'(rsp_valid), 32'd0);
      applyStimulus(0, 32'd10, 32'd4, 4'(ALU_SUB));
      applyStimulus(1, 32'd10, 32'd4, 4'(ALU_OR));
      #1;
      checkOutput("t6_grant0", 32'(req_ready), 32'b0001);
      tick();
      req_valid[0] = 1'b0;
      tick();
      #1;
      checkRsp("t6_rsp0", 32'd6, 32'd0, 1'b0);
      checkOutput("t6_grant1", 32'(req_ready), 32'b0010);
      tick();
      req_valid[1] = 1'b0;
      tick();
      #1;
      checkRsp("t6_rsp1", 32'hE, 32'd1, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
